// File: rtl/qspi_master_tx.sv
// qspi_master_tx: mode-0, MSB-first single-lane SPI initiator with full-duplex capture,
// back-to-back byte bursts and a programmable chip-select gap between frames.
module qspi_master_tx #(
  parameter int CLKDIV = 4,
  parameter int CS_GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] txdata,
  input  logic       txvalid,
  output logic       txready,
  output logic [7:0] rxdata,
  output logic       rxvalid,
  output logic       busy,
  output logic       QCK,
  output logic       QSS,
  output logic       QDO,
  input  logic       QDI
);
  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;
  state_t state;
  logic [7:0] div;
  logic [2:0] bitn;
  logic [6:0] sh;
  logic [6:0] rx;
  logic div_end, gap_end;
  assign div_end = div == 8'(CLKDIV - 1);
  assign gap_end = div == 8'(CS_GAP - 1);
  // ready in IDLE and in the last cycle of bit 7 so a waiting byte follows with no gap
  assign txready = !reset && (state == IDLE || (state == SHIFT_HI && bitn == 3'd7 && div_end));
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      div     <= '0;
      bitn    <= '0;
      sh      <= '0;
      rx      <= '0;
      rxdata  <= '0;
      rxvalid <= 1'b0;
      busy    <= 1'b0;
      QCK     <= 1'b0;
      QSS     <= 1'b1;
      QDO     <= 1'b0;
    end else begin
      rxvalid <= 1'b0;
      case (state)
        IDLE: if (txvalid) begin
          sh    <= txdata[6:0];
          QDO   <= txdata[7];
          QSS   <= 1'b0;
          busy  <= 1'b1;
          div   <= '0;
          bitn  <= '0;
          state <= SHIFT_LO;
        end
        SHIFT_LO: begin
          div <= div_end ? '0 : div + 8'd1;
          if (div_end) begin
            QCK   <= 1'b1;
            state <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          div <= div_end ? '0 : div + 8'd1;
          if (div_end) begin
            QCK  <= 1'b0;
            bitn <= bitn + 3'd1;
            rx   <= {rx[5:0], QDI};
            if (bitn == 3'd7) begin
              rxdata  <= {rx, QDI};
              rxvalid <= 1'b1;
              if (txvalid) begin
                sh    <= txdata[6:0];
                QDO   <= txdata[7];
                state <= SHIFT_LO;
              end else state <= HOLD;
            end else begin
              QDO   <= sh[6];
              sh    <= {sh[5:0], 1'b0};
              state <= SHIFT_LO;
            end
          end
        end
        HOLD: begin
          div <= div_end ? '0 : div + 8'd1;
          if (div_end) begin
            QSS   <= 1'b1;
            state <= GAP;
          end
        end
        GAP: begin
          div <= gap_end ? '0 : div + 8'd1;
          if (gap_end) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qspi_master_tx.sv
// tb_qspi_master_tx: three initiators (CLKDIV 4, 1, 255) checked every cycle against a
// phase-based frame model, plus directed scenarios with hand-computed timing.
module tb_qspi_master_tx;
  localparam int G = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] txdata[3], rxdata[3];
  logic txvalid[3], txready[3], rxvalid[3], busy[3], qck[3], qss[3], qdo[3], qdi[3];
  bit loopb[3] = '{1, 1, 1};
  logic [7:0] resp_byte = 8'h3C;
  logic [2:0] rcnt = '0;
  int ecnt = 0, checks = 0, failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic int cd(input int i);
    return i == 0 ? 4 : i == 1 ? 1 : 255;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    qspi_master_tx #(.CLKDIV(g == 0 ? 4 : g == 1 ? 1 : 255), .CS_GAP(G)) u (
      .clk(clk), .reset(reset), .txdata(txdata[g]), .txvalid(txvalid[g]),
      .txready(txready[g]), .rxdata(rxdata[g]), .rxvalid(rxvalid[g]), .busy(busy[g]),
      .QCK(qck[g]), .QSS(qss[g]), .QDO(qdo[g]), .QDI(qdi[g]));
    assign qdi[g] = loopb[g] ? qdo[g] : (g == 0 ? resp_byte[3'd7 - rcnt] : 1'b0);
  end

  // responder on instance 0: next bit after every falling QCK, restart while deselected
  always @(negedge qck[0] or posedge qss[0]) rcnt <= qss[0] ? 3'd0 : rcnt + 3'd1;

  task automatic chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h want=%0h edge=%0d", nm, i, a, e, ecnt);
    end
  endtask

  // frame model: outputs follow from the phase p = edges since the acceptance edge
  bit armed = 0, r_s = 1;
  bit act[3], v_s[3], rdy_s[3];
  int e0m[3];
  logic [7:0] md[3], mrx[3], mrxd[3], d_s[3];
  logic mqdo[3], q_s[3];
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int c, p;
      logic e_qss, e_qck, e_qdo, e_busy, e_rdy, e_rv;
      c = cd(i);
      e_rv = 1'b0;
      if (r_s) begin
        act[i] = 0;
        mqdo[i] = 1'b0;
        mrxd[i] = 8'h00;
        armed = 1;
      end else if (act[i]) begin
        p = ecnt - e0m[i];
        if (p > 0 && p <= 16 * c && p % (2 * c) == 0) mrx[i] = {mrx[i][6:0], q_s[i]};
        if (p == 16 * c) begin
          mrxd[i] = mrx[i];
          e_rv = 1'b1;
          if (v_s[i] && rdy_s[i]) begin
            e0m[i] = ecnt;
            md[i] = d_s[i];
          end
        end else if (p == 17 * c + G) begin
          act[i] = 0;
          mqdo[i] = md[i][0];
        end
      end else if (v_s[i] && rdy_s[i]) begin
        act[i] = 1;
        e0m[i] = ecnt;
        md[i] = d_s[i];
      end
      p = ecnt - e0m[i];
      if (!act[i]) {e_qss, e_qck, e_qdo, e_busy, e_rdy} = {1'b1, 1'b0, mqdo[i], 1'b0, 1'b1};
      else if (p < 16 * c)
        {e_qss, e_qck, e_qdo, e_busy, e_rdy} = {1'b0, 1'((p / c) % 2), md[i][7 - p / (2 * c)], 1'b1, 1'(p == 16 * c - 1)};
      else {e_qss, e_qck, e_qdo, e_busy, e_rdy} = {1'(p >= 17 * c), 1'b0, md[i][0], 1'b1, 1'b0};
      e_rdy = e_rdy && !reset;
      if (armed) begin
        chk("qss", i, 32'(qss[i]), 32'(e_qss));
        chk("qck", i, 32'(qck[i]), 32'(e_qck));
        chk("qdo", i, 32'(qdo[i]), 32'(e_qdo));
        chk("busy", i, 32'(busy[i]), 32'(e_busy));
        chk("txready", i, 32'(txready[i]), 32'(e_rdy));
        chk("rxvalid", i, 32'(rxvalid[i]), 32'(e_rv));
        chk("rxdata", i, 32'(rxdata[i]), 32'(mrxd[i]));
      end
      v_s[i] = txvalid[i];
      d_s[i] = txdata[i];
      q_s[i] = qdi[i];
      rdy_s[i] = e_rdy;
    end
    r_s = reset;
  end

  int first_rise, rises, rv_cnt, qss_rise, qlow, rdy_back, acc_cnt, qck_breaks, qdo_low;
  int rv_rel[4], acc_rel[4];
  logic [7:0] rxd[4];

  // offers nb bytes by handshake; late>=0 holds bytes after the first until that phase
  task automatic run(input int i, input logic [7:0] b0, b1, b2, input int nb, late, ncyc);
    logic [7:0] bq[3];
    int e0, sent, rel;
    logic prdy, pqck, pqss;
    bq[0] = b0; bq[1] = b1; bq[2] = b2;
    @(posedge clk); #1;
    e0 = ecnt + 1;
    txdata[i] = b0;
    txvalid[i] = 1'b1;
    sent = 0; prdy = txready[i]; pqck = 1'b0; pqss = 1'b1;
    first_rise = -1; rises = 0; rv_cnt = 0; qss_rise = -1; qlow = 0; rdy_back = -1;
    acc_cnt = 0; qck_breaks = 0; qdo_low = 0;
    for (int j = 0; j < ncyc; j++) begin
      @(posedge clk); #1;
      rel = ecnt - e0;
      if (txvalid[i] && prdy) begin
        if (acc_cnt < 4) acc_rel[acc_cnt] = rel;
        acc_cnt++;
        sent++;
        if (sent < nb && late < 0) txdata[i] = bq[sent];
        else txvalid[i] = 1'b0;
      end
      if (late >= 0 && rel == late && sent < nb) begin
        txdata[i] = bq[sent];
        txvalid[i] = 1'b1;
      end
      if (qck[i] && !pqck) begin
        rises++;
        if (first_rise < 0) first_rise = rel;
      end
      if (rel < 48 && qck[i] !== rel[0]) qck_breaks++;
      if (rxvalid[i]) begin
        if (rv_cnt < 4) begin
          rv_rel[rv_cnt] = rel;
          rxd[rv_cnt] = rxdata[i];
        end
        rv_cnt++;
      end
      if (!qss[i]) begin
        qlow++;
        if (!qdo[i]) qdo_low++;
      end
      if (qss[i] && !pqss && qss_rise < 0) qss_rise = rel;
      if (txready[i] && qss_rise >= 0 && rdy_back < 0) rdy_back = rel;
      pqck = qck[i]; pqss = qss[i]; prdy = txready[i];
    end
    txvalid[i] = 1'b0;
  endtask

  initial begin
    int e0, rel;
    logic pqck;
    for (int i = 0; i < 3; i++) begin
      txdata[i] = 8'h00;
      txvalid[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_qss", 0, 32'(qss[0]), 1);
    chk("rst_qck", 0, 32'(qck[0]), 0);
    chk("rst_qdo", 0, 32'(qdo[0]), 0);
    chk("rst_txready", 0, 32'(txready[0]), 0);
    chk("rst_rxdata", 0, 32'(rxdata[0]), 0);
    chk("rst_rxvalid", 0, 32'(rxvalid[0]), 0);
    chk("rst_busy", 0, 32'(busy[0]), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // loopback 0xA5; rxvalid set at edge E0+64 is seen by a consumer at E0+65
    run(0, 8'hA5, 8'h00, 8'h00, 1, -1, 80);
    chk("a5_accept", 0, acc_rel[0], 0);
    chk("a5_rises", 0, rises, 8);
    chk("a5_first_rise", 0, first_rise, 4);
    chk("a5_rv_cnt", 0, rv_cnt, 1);
    chk("a5_rv_rel", 0, rv_rel[0], 64);
    chk("a5_rxdata", 0, rxd[0], 8'hA5);
    chk("a5_qss_rise", 0, qss_rise, 68);
    chk("a5_ready_back", 0, rdy_back, 70);
    chk("a5_qss_low", 0, qlow, 68);

    loopb[0] = 0;
    run(0, 8'hFF, 8'h00, 8'h00, 1, -1, 80);
    chk("resp_rxdata", 0, rxd[0], 8'h3C);
    chk("resp_rv_cnt", 0, rv_cnt, 1);
    chk("resp_qdo_low", 0, qdo_low, 0);
    loopb[0] = 1;

    // second byte offered during HOLD waits for IDLE and is sent once
    run(0, 8'h11, 8'h22, 8'h00, 2, 65, 150);
    chk("late_acc_cnt", 0, acc_cnt, 2);
    chk("late_acc_rel", 0, acc_rel[1], 71);
    chk("late_ready_back", 0, rdy_back, 70);
    chk("late_rv_cnt", 0, rv_cnt, 2);
    chk("late_rv_rel", 0, rv_rel[1], 135);
    chk("late_rx0", 0, rxd[0], 8'h11);
    chk("late_rx1", 0, rxd[1], 8'h22);

    @(posedge clk); #1;
    e0 = ecnt + 1;
    txdata[0] = 8'h81;
    txvalid[0] = 1'b1;
    rises = 0; pqck = 1'b0; rel = -1;
    for (int j = 0; j < 40 && rises < 3; j++) begin
      @(posedge clk); #1;
      rel = ecnt - e0;
      txvalid[0] = 1'b0;
      if (qck[0] && !pqck) rises++;
      pqck = qck[0];
    end
    chk("mid_third_rise", 0, rel, 20);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_qss", 0, 32'(qss[0]), 1);
    chk("mid_qck", 0, 32'(qck[0]), 0);
    chk("mid_qdo", 0, 32'(qdo[0]), 0);
    chk("mid_busy", 0, 32'(busy[0]), 0);
    rv_cnt = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (rxvalid[0]) rv_cnt++;
    end
    chk("mid_no_rxvalid", 0, rv_cnt, 0);
    run(0, 8'h42, 8'h00, 8'h00, 1, -1, 80);
    chk("post_rxdata", 0, rxd[0], 8'h42);
    chk("post_rv_cnt", 0, rv_cnt, 1);

    run(1, 8'h01, 8'h02, 8'h03, 3, -1, 60);
    chk("burst_acc1", 1, acc_rel[1], 16);
    chk("burst_acc2", 1, acc_rel[2], 32);
    chk("burst_rises", 1, rises, 24);
    chk("burst_qck_breaks", 1, qck_breaks, 0);
    chk("burst_qss_rise", 1, qss_rise, 49);
    chk("burst_rv_cnt", 1, rv_cnt, 3);
    chk("burst_rv0", 1, rv_rel[0], 16);
    chk("burst_rv1", 1, rv_rel[1], 32);
    chk("burst_rv2", 1, rv_rel[2], 48);
    chk("burst_rx0", 1, rxd[0], 8'h01);
    chk("burst_rx1", 1, rxd[1], 8'h02);
    chk("burst_rx2", 1, rxd[2], 8'h03);

    run(2, 8'h5A, 8'h00, 8'h00, 1, -1, 17 * 255 + 5);
    chk("slow_first_rise", 2, first_rise, 255);
    chk("slow_rises", 2, rises, 8);
    chk("slow_qss_low", 2, qlow, 17 * 255);
    chk("slow_rxdata", 2, rxd[0], 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qspi_master_tx.md
# qspi_master_tx

Single-lane SPI initiator (mode 0, MSB first) for the FPGA side. It drives QCK/QSS/QDO toward a serial responder and captures QDI in full duplex. It sits on the fabric clock (`clk`, typically the 100 MHz divided PLL clock) and gives the opposite end of the link served by the existing QSPI slave receiver/transmitter pair. This lets that pair be exercised in-fabric (loopback) or lets the FPGA talk to external SPI responders.

## Interface
Parameters:
- CLKDIV, 4: QCK half-period in `clk` cycles; legal range 1..255; QCK = f(clk)/(2*CLKDIV).
- CS_GAP, 2: minimum QSS-high cycles between frames; legal range 1..255.

Ports:
- clk  in  1  fabric clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- txdata  in  8  byte to transmit; sampled on acceptance.
- txvalid  in  1  txdata is valid.
- txready  out  1  block can accept a byte this cycle; transfer occurs when txvalid && txready.
- rxdata  out  8  last byte received on QDI; held until the next rxvalid.
- rxvalid  out  1  one-cycle pulse; rxdata was updated this cycle.
- busy  out  1  frame in progress, including the CS gap.
- QCK  out  1  serial clock; idles low.
- QSS  out  1  chip select, active low.
- QDO  out  1  serial data to the responder.
- QDI  in  1  serial data from the responder; treated as already synchronous.

## Operation
- States: IDLE, SHIFT_LO, SHIFT_HI, HOLD, GAP.
- IDLE:
  - txready=1, QSS=1, QCK=0, busy=0.
  - On acceptance: load the shift register with txdata, QDO=txdata[7], QSS=0, and enter SHIFT_LO with bit counter=0.
- SHIFT_LO (QCK=0) lasts CLKDIV cycles, then go to SHIFT_HI with QCK=1 (rising edge).
- SHIFT_HI (QCK=1) lasts CLKDIV cycles.
  - On the exiting edge: QCK=0, QDI is shifted into the rx register (sampled at the end of the high phase, just before the falling edge), and the counter increments.
  - For bits 0..6: present the next tx bit on QDO and return to SHIFT_LO.
- Bit 7 exit edge (end of byte):
  - rxdata is updated and rxvalid=1 for one cycle.
  - txready is 1 during the last cycle of bit 7's SHIFT_HI (burst window). If txvalid is high then, the new byte is loaded, QDO is set to its bit 7, and the FSM enters SHIFT_LO. QSS stays low, giving a continuous QCK with no gap.
  - Otherwise the FSM enters HOLD.
- HOLD: QSS=0, QCK=0 for CLKDIV cycles, then QSS=1 and enter GAP.
- GAP: QSS=1, txready=0, busy=1 for CS_GAP cycles, then IDLE.
- txready is 0 in every state and cycle other than IDLE and the burst window.
- Reset values: QSS=1, QCK=0, QDO=0, txready=0 while reset is asserted, rxdata=0x00, rxvalid=0, busy=0, state=IDLE, counters=0.
- Reset mid-frame:
  - Return to IDLE on the next edge; QSS goes high immediately, without HOLD or GAP.
  - No rxvalid is produced and the partial byte is discarded.
- txvalid changing while txready=0 has no effect; bytes are never dropped or duplicated.
- rxdata width: exactly 8 bits, MSB received first lands in rxdata[7].

## Timing
- Let E0 be the acceptance edge from IDLE.
- From E0: QSS=0, QCK=0, and QDO=d[7].
- Bit k (k=0..7, MSB first):
  - QCK rises at E0+(2k+1)*CLKDIV.
  - QCK falls at E0+(2k+2)*CLKDIV.
  - QDI is sampled at that falling edge.
  - QDO changes only on falling edges.
- rxvalid is high in the cycle after E0+16*CLKDIV.
- Burst acceptance occurs at edge E0+16*CLKDIV; the next byte's first rising edge is at E0+17*CLKDIV.
- Frame end without burst:
  - QSS rises at E0+17*CLKDIV.
  - txready returns at E0+17*CLKDIV+CS_GAP.
- Minimum single-byte turnaround: 17*CLKDIV+CS_GAP cycles.
- All outputs are registered; there is no combinational path from inputs to outputs except txready from state.

## Test plan
- CLKDIV=4, CS_GAP=2, QDI looped to QDO, send 0xA5:
  - exactly 8 QCK rising edges, with the first at E0+4;
  - rxdata=0xA5 with rxvalid at E0+65;
  - QSS high at E0+68;
  - txready high again at E0+70.
- CLKDIV=1, txvalid held with 0x01, 0x02, 0x03 back-to-back:
  - QSS stays low for all 24 bits;
  - QCK is continuous, with no gap between bytes;
  - three rxvalid pulses, 16 cycles apart.
- Responder model shifting 0x3C on QDI (changing on QCK falling edges) while sending 0xFF: rxdata=0x3C, and QDO is high for all 8 bits.
- Reset asserted after the 3rd rising QCK edge of byte 0x81:
  - QSS=1, QCK=0, QDO=0 on the next edge;
  - no rxvalid;
  - the next byte 0x42 transfers cleanly with rxdata=0x42 in loopback.
- txvalid asserted during HOLD/GAP: not accepted until IDLE (txready=0 throughout), and the byte is sent exactly once afterward.
- CLKDIV=255 single byte: first QCK rising edge at E0+255, and total frame QSS-low time equals 17*255 cycles.
